// File: rtl/cel_deadtime_driver.sv
// cel_deadtime_driver: NCH-channel complementary half-bridge gate driver with programmable
// break-before-make dead time. Optional minimum on-time hold: define CEL_DRV_MINON_EN.
//
// state | meaning
// OFF   | disabled by en=0, both drives low
// DT2B  | dead time counting toward bottom-on
// BOT   | low-side drive on
// DT2T  | dead time counting toward top-on
// TOP   | high-side drive on
module cel_deadtime_driver #(
    parameter int NCH   = 2,
    parameter int DTW   = 4,
    parameter int INV   = 1,
    parameter int MINON = 3
) (
    input  logic           CELCLK,
    input  logic           CELRSTN,
    input  logic           CELV,
    input  logic           CELG,
    input  logic           SUB,
    input  logic           en,
    input  logic [DTW-1:0] dt_cfg,
    input  logic [NCH-1:0] i,
    output logic [NCH-1:0] o_top,
    output logic [NCH-1:0] o_bot,
    output logic [NCH-1:0] busy
);

    typedef enum logic [2:0] {
        S_OFF  = 3'd0,
        S_DT2B = 3'd1,
        S_BOT  = 3'd2,
        S_DT2T = 3'd3,
        S_TOP  = 3'd4
    } state_t;

    logic [NCH-1:0] s1;
    logic [NCH-1:0] s2;
    logic [NCH-1:0] dmd;

    // Supply/substrate pins exist only for the netlist; they carry no logic.
    logic unused_pins;
    assign unused_pins = CELV ^ CELG ^ SUB;

`ifndef CEL_DRV_MINON_EN
    logic [31:0] unused_minon;
    assign unused_minon = MINON;
`endif

    always_ff @(posedge CELCLK or negedge CELRSTN) begin
        if (!CELRSTN) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= i;
            s2 <= s1;
        end
    end

    assign dmd = (INV != 0) ? ~s2 : s2;

    for (genvar n = 0; n < NCH; n++) begin : g_ch
        state_t         state;
        state_t         state_nx;
        logic [DTW-1:0] cnt;
        logic [DTW-1:0] cnt_nx;
        logic           rev_ok;
        logic           top_q;
        logic           bot_q;
        logic           busy_q;

        // A demand that disagrees with the pending side restarts the full dead time,
        // so an abort can never shorten the gap.
        always_comb begin
            state_nx = state;
            cnt_nx   = cnt;
            if (!en) begin
                state_nx = S_OFF;
                cnt_nx   = '0;
            end else begin
                case (state)
                    S_OFF: begin
                        state_nx = S_DT2B;
                        cnt_nx   = dt_cfg;
                    end
                    S_DT2B: begin
                        if (dmd[n]) begin
                            state_nx = S_DT2T;
                            cnt_nx   = dt_cfg;
                        end else if (cnt != '0) begin
                            cnt_nx = cnt - DTW'(1);
                        end else begin
                            state_nx = S_BOT;
                        end
                    end
                    S_BOT: begin
                        if (dmd[n] && rev_ok) begin
                            state_nx = S_DT2T;
                            cnt_nx   = dt_cfg;
                        end
                    end
                    S_DT2T: begin
                        if (!dmd[n]) begin
                            state_nx = S_DT2B;
                            cnt_nx   = dt_cfg;
                        end else if (cnt != '0) begin
                            cnt_nx = cnt - DTW'(1);
                        end else begin
                            state_nx = S_TOP;
                        end
                    end
                    S_TOP: begin
                        if (!dmd[n] && rev_ok) begin
                            state_nx = S_DT2B;
                            cnt_nx   = dt_cfg;
                        end
                    end
                    default: begin
                        state_nx = S_OFF;
                        cnt_nx   = '0;
                    end
                endcase
            end
        end

`ifdef CEL_DRV_MINON_EN
        localparam int OW = (MINON > 1) ? $clog2(MINON) : 1;
        logic [OW-1:0] on_cnt;
        logic [OW-1:0] on_cnt_nx;

        always_comb begin
            on_cnt_nx = on_cnt;
            if (!en) begin
                on_cnt_nx = '0;
            end else if ((state_nx == S_TOP && state != S_TOP) ||
                         (state_nx == S_BOT && state != S_BOT)) begin
                on_cnt_nx = OW'(MINON - 1);
            end else if (on_cnt != '0) begin
                on_cnt_nx = on_cnt - OW'(1);
            end
        end

        always_ff @(posedge CELCLK or negedge CELRSTN) begin
            if (!CELRSTN) begin
                on_cnt <= '0;
            end else begin
                on_cnt <= on_cnt_nx;
            end
        end

        assign rev_ok = (on_cnt == '0);
`else
        assign rev_ok = 1'b1;
`endif

        // Drives are registered from the next state, so top and bottom are mutually
        // exclusive by construction and never glitch on state decode.
        always_ff @(posedge CELCLK or negedge CELRSTN) begin
            if (!CELRSTN) begin
                state  <= S_OFF;
                cnt    <= '0;
                top_q  <= 1'b0;
                bot_q  <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                state  <= state_nx;
                cnt    <= cnt_nx;
                top_q  <= (state_nx == S_TOP);
                bot_q  <= (state_nx == S_BOT);
                busy_q <= (state_nx == S_DT2B) || (state_nx == S_DT2T);
            end
        end

        assign o_top[n] = top_q;
        assign o_bot[n] = bot_q;
        assign busy[n]  = busy_q;
    end

endmodule

// File: tb/tb_cel_deadtime_driver.sv
// Bench for cel_deadtime_driver: directed latency/abort/enable/reset scenarios plus randomized
// demand, all compared against a side/gap-level reference model.
module tb_cel_deadtime_driver;

    localparam int NCH   = 2;
    localparam int DTW   = 4;
    localparam int INV   = 1;
    localparam int MINON = 3;
`ifdef CEL_DRV_MINON_EN
    localparam int HOLD = MINON - 1;
`else
    localparam int HOLD = 0;
`endif

    logic           CELCLK  = 1'b0;
    logic           CELRSTN = 1'b1;
    logic           CELV    = 1'b1;
    logic           CELG    = 1'b0;
    logic           SUB     = 1'b0;
    logic           en      = 1'b0;
    logic [DTW-1:0] dt_cfg  = '0;
    logic [NCH-1:0] i       = '0;
    logic [NCH-1:0] o_top;
    logic [NCH-1:0] o_bot;
    logic [NCH-1:0] busy;

    int n_vec = 0;
    int n_err = 0;

    // Model: which side is driven (0 none, 1 bottom, 2 top), which side a gap heads for,
    // cycles of gap left, and min-on cycles left; demand reaches it two edges late.
    int             m_drv [NCH];
    int             m_goal[NCH];
    int             m_rem [NCH];
    int             m_held[NCH];
    bit             m_act [NCH];
    logic [NCH-1:0] m_p1, m_p2;
    logic [NCH-1:0] m_top, m_bot, m_busy;

    always #5 CELCLK = ~CELCLK;

    cel_deadtime_driver #(.NCH(NCH), .DTW(DTW), .INV(INV), .MINON(MINON)) dut (
        .CELCLK (CELCLK),
        .CELRSTN(CELRSTN),
        .CELV   (CELV),
        .CELG   (CELG),
        .SUB    (SUB),
        .en     (en),
        .dt_cfg (dt_cfg),
        .i      (i),
        .o_top  (o_top),
        .o_bot  (o_bot),
        .busy   (busy)
    );

    task automatic model_reset();
        for (int n = 0; n < NCH; n++) begin
            m_drv[n] = 0; m_goal[n] = 0; m_rem[n] = 0; m_held[n] = 0; m_act[n] = 0;
        end
        m_p1 = '0; m_p2 = '0; m_top = '0; m_bot = '0; m_busy = '0;
    endtask

    task automatic model_step();
        if (!CELRSTN) begin
            model_reset();
            return;
        end
        for (int n = 0; n < NCH; n++) begin
            int want;
            want = (((INV != 0) ? !m_p2[n] : m_p2[n]) != 0) ? 2 : 1;
            if (!en) begin
                m_act[n] = 0;
                m_drv[n] = 0;
            end else if (!m_act[n]) begin
                m_act[n]  = 1;
                m_drv[n]  = 0;
                m_goal[n] = 1;
                m_rem[n]  = int'(dt_cfg);
            end else if (m_drv[n] == 0) begin
                if (want != m_goal[n]) begin
                    m_goal[n] = want;
                    m_rem[n]  = int'(dt_cfg);
                end else if (m_rem[n] > 0) begin
                    m_rem[n]--;
                end else begin
                    m_drv[n]  = m_goal[n];
                    m_held[n] = HOLD;
                end
            end else begin
                if (want != m_drv[n] && m_held[n] == 0) begin
                    m_drv[n]  = 0;
                    m_goal[n] = want;
                    m_rem[n]  = int'(dt_cfg);
                end else if (m_held[n] > 0) begin
                    m_held[n]--;
                end
            end
            m_p2[n]   = m_p1[n];
            m_p1[n]   = i[n];
            m_top[n]  = (m_drv[n] == 2);
            m_bot[n]  = (m_drv[n] == 1);
            m_busy[n] = m_act[n] && (m_drv[n] == 0);
        end
    endtask

    task automatic cyc();
        @(posedge CELCLK);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        #1 CELRSTN = 1'b0;
        model_reset();
        #2;
        n_vec++;
        if ({o_top, o_bot, busy} !== '0) begin
            n_err++;
            $display("FAIL reset_async: got top=%b bot=%b busy=%b, want all 0", o_top, o_bot, busy);
        end
        en = 1'b1; i = '1; dt_cfg = 4'd1;
        repeat (2) begin
            cyc();
            n_vec++;
            if ({o_top, o_bot, busy} !== {m_top, m_bot, m_busy}) begin
                n_err++;
                $display("FAIL reset_hold: got top=%b bot=%b busy=%b, want top=%b bot=%b busy=%b",
                         o_top, o_bot, busy, m_top, m_bot, m_busy);
            end
        end
        CELRSTN = 1'b1; en = 1'b0;
        repeat (2) begin
            cyc();
            n_vec++;
            if ({o_top, o_bot, busy} !== {m_top, m_bot, m_busy}) begin
                n_err++;
                $display("FAIL reset_release: got top=%b bot=%b busy=%b, want top=%b bot=%b busy=%b",
                         o_top, o_bot, busy, m_top, m_bot, m_busy);
            end
        end
    endtask

    task automatic test_power_up();
        int rise_k;
        rise_k = -1;
        i = '1; dt_cfg = 4'd2; en = 1'b0;
        repeat (3) cyc();
        en = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            n_vec++;
            if ({o_top, o_bot, busy} !== {m_top, m_bot, m_busy}) begin
                n_err++;
                $display("FAIL pwrup_model k=%0d: got top=%b bot=%b busy=%b, want top=%b bot=%b busy=%b",
                         k, o_top, o_bot, busy, m_top, m_bot, m_busy);
            end
            n_vec++;
            if (o_top !== '0) begin
                n_err++;
                $display("FAIL pwrup_top k=%0d: got top=%b, want 00", k, o_top);
            end
            if (rise_k < 0 && o_bot[0] === 1'b1) rise_k = k;
        end
        n_vec++;
        if (rise_k != 4) begin
            n_err++;
            $display("FAIL pwrup_bot_rise: got edge %0d, want edge 4", rise_k);
        end
    endtask

    task automatic test_latency();
        int fall_k, rise_k, nb;
        fall_k = -1; rise_k = -1; nb = 0;
        dt_cfg = 4'd3; i = '0;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            n_vec++;
            if ({o_top, o_bot, busy} !== {m_top, m_bot, m_busy}) begin
                n_err++;
                $display("FAIL latency_model k=%0d: got top=%b bot=%b busy=%b, want top=%b bot=%b busy=%b",
                         k, o_top, o_bot, busy, m_top, m_bot, m_busy);
            end
            if (fall_k < 0 && o_bot[0] === 1'b0) fall_k = k;
            if (rise_k < 0 && o_top[0] === 1'b1) rise_k = k;
            if (busy[0] === 1'b1) nb++;
        end
        n_vec++;
        if (fall_k != 3 || rise_k != 7 || nb != 4) begin
            n_err++;
            $display("FAIL latency_edges: got fall=%0d rise=%0d busy=%0d, want fall=3 rise=7 busy=4",
                     fall_k, rise_k, nb);
        end
    endtask

    task automatic test_abort();
        int fall_k, rise_k, nb, tops;
        fall_k = -1; rise_k = -1; nb = 0; tops = 0;
        i = '1; dt_cfg = 4'd3;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            n_vec++;
            if ({o_top, o_bot, busy} !== {m_top, m_bot, m_busy}) begin
                n_err++;
                $display("FAIL abort_setup k=%0d: got top=%b bot=%b busy=%b, want top=%b bot=%b busy=%b",
                         k, o_top, o_bot, busy, m_top, m_bot, m_busy);
            end
        end
        dt_cfg = 4'd5; i = '0;
        for (int k = 1; k <= 14; k++) begin
            cyc();
            if (k == 1) i = '1;
            n_vec++;
            if ({o_top, o_bot, busy} !== {m_top, m_bot, m_busy}) begin
                n_err++;
                $display("FAIL abort_model k=%0d: got top=%b bot=%b busy=%b, want top=%b bot=%b busy=%b",
                         k, o_top, o_bot, busy, m_top, m_bot, m_busy);
            end
            if (fall_k < 0 && o_bot[0] === 1'b0) fall_k = k;
            if (fall_k > 0 && rise_k < 0 && o_bot[0] === 1'b1) rise_k = k;
            if (busy[0] === 1'b1) nb++;
            if (o_top[0] !== 1'b0) tops++;
        end
        n_vec++;
        if (fall_k != 3 || rise_k != 10 || nb != 7 || tops != 0) begin
            n_err++;
            $display("FAIL abort_edges: got fall=%0d rise=%0d busy=%0d top_cycles=%0d, want 3 10 7 0",
                     fall_k, rise_k, nb, tops);
        end
    endtask

    task automatic test_en_drop();
        i = '0; dt_cfg = 4'd1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            n_vec++;
            if ({o_top, o_bot, busy} !== {m_top, m_bot, m_busy}) begin
                n_err++;
                $display("FAIL endrop_setup k=%0d: got top=%b bot=%b busy=%b, want top=%b bot=%b busy=%b",
                         k, o_top, o_bot, busy, m_top, m_bot, m_busy);
            end
        end
        n_vec++;
        if (o_top !== '1) begin
            n_err++;
            $display("FAIL endrop_in_top: got top=%b, want 11", o_top);
        end
        en = 1'b0;
        cyc();
        n_vec++;
        if ({o_top, o_bot, busy} !== '0) begin
            n_err++;
            $display("FAIL endrop_off: got top=%b bot=%b busy=%b, want all 0", o_top, o_bot, busy);
        end
        en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            n_vec++;
            if ({o_top, o_bot, busy} !== {m_top, m_bot, m_busy}) begin
                n_err++;
                $display("FAIL endrop_reen k=%0d: got top=%b bot=%b busy=%b, want top=%b bot=%b busy=%b",
                         k, o_top, o_bot, busy, m_top, m_bot, m_busy);
            end
        end
    endtask

    task automatic test_reset_mid_dt();
        i = '1; dt_cfg = 4'd1;
        repeat (10) cyc();
        dt_cfg = 4'd9; i = '0;
        for (int k = 1; k <= 5; k++) begin
            cyc();
            n_vec++;
            if ({o_top, o_bot, busy} !== {m_top, m_bot, m_busy}) begin
                n_err++;
                $display("FAIL rstmid_setup k=%0d: got top=%b bot=%b busy=%b, want top=%b bot=%b busy=%b",
                         k, o_top, o_bot, busy, m_top, m_bot, m_busy);
            end
        end
        n_vec++;
        if (busy !== '1 || o_top !== '0 || o_bot !== '0) begin
            n_err++;
            $display("FAIL rstmid_in_dt: got top=%b bot=%b busy=%b, want 00 00 11", o_top, o_bot, busy);
        end
        #2 CELRSTN = 1'b0;
        #1;
        n_vec++;
        if ({o_top, o_bot, busy} !== '0) begin
            n_err++;
            $display("FAIL rstmid_async: got top=%b bot=%b busy=%b, want all 0", o_top, o_bot, busy);
        end
        cyc();
        CELRSTN = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            cyc();
            n_vec++;
            if ({o_top, o_bot, busy} !== {m_top, m_bot, m_busy}) begin
                n_err++;
                $display("FAIL rstmid_recover k=%0d: got top=%b bot=%b busy=%b, want top=%b bot=%b busy=%b",
                         k, o_top, o_bot, busy, m_top, m_bot, m_busy);
            end
        end
    endtask

    task automatic test_dt0_phases();
        int low[NCH];
        for (int n = 0; n < NCH; n++) low[n] = 0;
        en = 1'b1; dt_cfg = 4'd0; i = 2'b01;
        repeat (12) cyc();
        for (int k = 0; k < 48; k++) begin
            if (k % 4 == 0) i = ~i;
            cyc();
            n_vec++;
            if ({o_top, o_bot, busy} !== {m_top, m_bot, m_busy}) begin
                n_err++;
                $display("FAIL dt0_model k=%0d: got top=%b bot=%b busy=%b, want top=%b bot=%b busy=%b",
                         k, o_top, o_bot, busy, m_top, m_bot, m_busy);
            end
            n_vec++;
            if ((o_top & o_bot) !== '0) begin
                n_err++;
                $display("FAIL dt0_overlap k=%0d: got top&bot=%b, want 00", k, o_top & o_bot);
            end
            for (int n = 0; n < NCH; n++) begin
                if (o_top[n] === 1'b0 && o_bot[n] === 1'b0) begin
                    low[n]++;
                end else begin
                    if (low[n] != 0) begin
                        n_vec++;
                        if (low[n] != 1) begin
                            n_err++;
                            $display("FAIL dt0_gap ch%0d k=%0d: got gap %0d, want 1", n, k, low[n]);
                        end
                    end
                    low[n] = 0;
                end
            end
        end
    endtask

`ifdef CEL_DRV_MINON_EN
    task automatic test_minon();
        int high;
        high = 0;
        en = 1'b1; dt_cfg = 4'd0; i = '1;
        repeat (12) cyc();
        i = '0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (k == 2) i = '1;
            n_vec++;
            if ({o_top, o_bot, busy} !== {m_top, m_bot, m_busy}) begin
                n_err++;
                $display("FAIL minon_model k=%0d: got top=%b bot=%b busy=%b, want top=%b bot=%b busy=%b",
                         k, o_top, o_bot, busy, m_top, m_bot, m_busy);
            end
            if (o_top[0] === 1'b1) high++;
        end
        n_vec++;
        if (high != MINON) begin
            n_err++;
            $display("FAIL minon_hold: got top high %0d cycles, want %0d", high, MINON);
        end
    endtask
`endif

    task automatic test_random();
        int rate;
        rate = 6;
        en = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (k % 200 == 0) rate = int'($urandom_range(2, 40));
            for (int n = 0; n < NCH; n++)
                if ($urandom_range(0, rate - 1) == 0) i[n] = ~i[n];
            if ($urandom_range(0, 15) == 0) dt_cfg = DTW'($urandom_range(0, (1 << DTW) - 1));
            if (en) begin
                if ($urandom_range(0, 99) == 0) en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                en = 1'b1;
            end
            if (k == 1500) CELRSTN = 1'b0;
            if (k == 1502) CELRSTN = 1'b1;
            cyc();
            n_vec++;
            if ({o_top, o_bot, busy} !== {m_top, m_bot, m_busy}) begin
                n_err++;
                $display("FAIL rand_model k=%0d: got top=%b bot=%b busy=%b, want top=%b bot=%b busy=%b",
                         k, o_top, o_bot, busy, m_top, m_bot, m_busy);
            end
            n_vec++;
            if ((o_top & o_bot) !== '0) begin
                n_err++;
                $display("FAIL rand_overlap k=%0d: got top&bot=%b, want 00", k, o_top & o_bot);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_power_up();
        test_latency();
        test_abort();
        test_en_drop();
        test_reset_mid_dt();
        test_dt0_phases();
`ifdef CEL_DRV_MINON_EN
        test_minon();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
